// File: rtl/soc_system_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// soc_system_pll_reset_ctrl
//
// Reset and lock supervisor for the SDRAM PLL, clocked by the 50 MHz refclk.
// It pulses the PLL reset for a guaranteed minimum time and synchronizes the
// PLL's asynchronous locked output. It keeps the downstream system reset
// asserted until lock has been continuously present for a programmable time.
// It re-initializes the PLL when lock is lost in RUN or never arrives.
//
// Parameters
//   RST_PULSE_CYCLES    : pll_rst high time per attempt, in refclk cycles (>=1)
//   LOCK_TIMEOUT_CYCLES : max wait for lock after pll_rst release (>=1)
//   LOCK_STABLE_CYCLES  : consecutive lock cycles required before RUN (>=1)
//   CNT_W               : width of relock_count
//
// Ports
//   refclk       in  : the only clock
//   rst          in  : synchronous, active-high reset
//   pll_locked   in  : PLL locked flag, asynchronous to refclk
//   pll_rst      out : PLL reset, active-high
//   sys_rst      out : downstream reset, active-high (low only in RUN)
//   lock_ok      out : high only in RUN
//   relock_count out : count of RUN -> RESET_PLL events, saturating
//   timeout_err  out : sticky lock-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module soc_system_pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES    = 50,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             lock_ok,
  output logic [CNT_W-1:0] relock_count,
  output logic             timeout_err
);

  // The shared counter only has to reach the largest terminal value (max-1),
  // so clog2 of the largest cycle parameter is enough; keep at least 1 bit.
  localparam int MAX_RT  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                           RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_RT > LOCK_STABLE_CYCLES) ? MAX_RT : LOCK_STABLE_CYCLES;
  localparam int CW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CW-1:0]    RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE      = CW'(1);
  localparam logic [CNT_W-1:0] RELOCK_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RELOCK_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             lock_meta_r;
  logic             lock_sync_r;     // lock_s: the only lock view the FSM uses
  logic             pll_rst_r;
  logic             sys_rst_r;
  logic             lock_ok_r;
  logic [CNT_W-1:0] relock_count_r;
  logic             timeout_err_r;

  // Two-flop synchronizer bringing pll_locked into the refclk domain.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Supervisor FSM; outputs are registered together with the state so that
  // they always equal the Moore decode of the state being entered.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r        <= ST_RESET_PLL;
      cnt_r          <= '0;
      pll_rst_r      <= 1'b1;
      sys_rst_r      <= 1'b1;
      lock_ok_r      <= 1'b0;
      relock_count_r <= '0;
      timeout_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RESET_PLL: begin
          if (cnt_r == RST_LAST) begin
            state_r   <= ST_WAIT_LOCK;
            cnt_r     <= '0;
            pll_rst_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_sync_r) begin
            state_r <= ST_STABLE;
            cnt_r   <= '0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            // Lock never came: flag it and retry with a fresh PLL reset.
            state_r       <= ST_RESET_PLL;
            cnt_r         <= '0;
            pll_rst_r     <= 1'b1;
            timeout_err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!lock_sync_r) begin
            // A lock glitch only restarts the wait; the PLL is not reset.
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == STABLE_LAST) begin
            state_r   <= ST_RUN;
            cnt_r     <= '0;
            sys_rst_r <= 1'b0;
            lock_ok_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_sync_r) begin
            state_r   <= ST_RESET_PLL;
            cnt_r     <= '0;
            pll_rst_r <= 1'b1;
            sys_rst_r <= 1'b1;
            lock_ok_r <= 1'b0;
            if (relock_count_r != RELOCK_MAX) begin
              relock_count_r <= relock_count_r + RELOCK_ONE;
            end else begin
              relock_count_r <= relock_count_r;
            end
          end else begin
            cnt_r <= '0;
          end
        end
        default: begin
          // Unreachable encoding: recover through a full PLL reset.
          state_r   <= ST_RESET_PLL;
          cnt_r     <= '0;
          pll_rst_r <= 1'b1;
          sys_rst_r <= 1'b1;
          lock_ok_r <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst      = pll_rst_r;
  assign sys_rst      = sys_rst_r;
  assign lock_ok      = lock_ok_r;
  assign relock_count = relock_count_r;
  assign timeout_err  = timeout_err_r;

endmodule
